// File: rtl/msx_ram_arbiter.sv
// Shares one byte-wide memory port between loader, CPU and device requesters; optional stats via RAM_ARB_STATS_EN.
// Latency: request seen in IDLE at t -> mem_ce at t+1 -> ack at t+3 when mem_done arrives at t+2.
// Backpressure: requests are levels held until their 1-cycle ack; the Z80 is stalled via cpu_wait_n meanwhile.
module msx_ram_arbiter #(
    parameter int ADDR_W    = 27,
    parameter int CPU_BURST = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_din,
    output logic              ld_ack,
    input  logic              cpu_req,
    input  logic              cpu_rnw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    output logic              cpu_wait_n,
    input  logic              dev_req,
    input  logic              dev_rnw,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic [7:0]        dev_din,
    output logic [7:0]        dev_dout,
    output logic              dev_ack,
    output logic              mem_ce,
    output logic              mem_rnw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_done,
    output logic              timeout_err
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_ld,
    output logic [15:0]       stat_cpu,
    output logic [15:0]       stat_dev,
    output logic [7:0]        stat_timeouts
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT_MEM, S_ACK} state_t;
    typedef enum logic [1:0] {W_LD, W_CPU, W_DEV} win_t;

    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [3:0] BURST_MAX = 4'(CPU_BURST);

    state_t            state, state_nxt;
    win_t              win, sel;
    logic              any_req;
    logic              dev_forced;
    logic              sel_rnw;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_din;
    logic [7:0]        to_cnt;
    logic              to_expire;
    logic [3:0]        burst_cnt;

    assign any_req    = ld_req | cpu_req | dev_req;
    assign dev_forced = dev_req && (burst_cnt == BURST_MAX);
    assign to_expire  = (to_cnt == TO_LAST);

    // Loader always wins; a starved device overtakes the CPU once the burst quota is used up.
    always_comb begin
        sel      = W_DEV;
        sel_rnw  = dev_rnw;
        sel_addr = dev_addr;
        sel_din  = dev_din;
        if (ld_req) begin
            sel      = W_LD;
            sel_rnw  = 1'b0;
            sel_addr = ld_addr;
            sel_din  = ld_din;
        end else if (cpu_req && !dev_forced) begin
            sel      = W_CPU;
            sel_rnw  = cpu_rnw;
            sel_addr = cpu_addr;
            sel_din  = cpu_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (any_req) state_nxt = S_GRANT;
            S_GRANT:    state_nxt = S_WAIT_MEM;
            S_WAIT_MEM: if (mem_done || to_expire) state_nxt = S_ACK;
            S_ACK:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    assign ld_ack     = (state == S_ACK) && (win == W_LD);
    assign cpu_ack    = (state == S_ACK) && (win == W_CPU);
    assign dev_ack    = (state == S_ACK) && (win == W_DEV);
    assign cpu_wait_n = ~(cpu_req & ~cpu_ack);

    // The memory strobe is raised on the arbitration edge so the port sees the request in GRANT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win         <= W_LD;
            mem_ce      <= 1'b0;
            mem_rnw     <= 1'b1;
            mem_addr    <= '0;
            mem_din     <= 8'h00;
            cpu_dout    <= 8'h00;
            dev_dout    <= 8'h00;
            timeout_err <= 1'b0;
            to_cnt      <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        win      <= sel;
                        mem_ce   <= 1'b1;
                        mem_rnw  <= sel_rnw;
                        mem_addr <= sel_addr;
                        mem_din  <= sel_din;
                    end
                end
                S_GRANT: to_cnt <= 8'h00;
                S_WAIT_MEM: begin
                    if (mem_done) begin
                        mem_ce <= 1'b0;
                        if (mem_rnw && win == W_CPU) cpu_dout <= mem_dout;
                        if (mem_rnw && win == W_DEV) dev_dout <= mem_dout;
                    end else if (to_expire) begin
                        mem_ce      <= 1'b0;
                        timeout_err <= 1'b1;
                        if (win == W_CPU) cpu_dout <= 8'hFF;
                        if (win == W_DEV) dev_dout <= 8'hFF;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt <= 4'd0;
        end else if (!dev_req) begin
            burst_cnt <= 4'd0;
        end else if (state == S_IDLE && any_req) begin
            if (sel == W_DEV)
                burst_cnt <= 4'd0;
            else if (sel == W_CPU && burst_cnt != BURST_MAX)
                burst_cnt <= burst_cnt + 4'd1;
        end
    end

`ifdef RAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_ld       <= 16'h0000;
            stat_cpu      <= 16'h0000;
            stat_dev      <= 16'h0000;
            stat_timeouts <= 8'h00;
        end else begin
            if (state == S_IDLE && any_req) begin
                case (sel)
                    W_LD:    stat_ld  <= stat_ld + 16'd1;
                    W_CPU:   stat_cpu <= stat_cpu + 16'd1;
                    default: stat_dev <= stat_dev + 16'd1;
                endcase
            end
            if (state == S_WAIT_MEM && !mem_done && to_expire && stat_timeouts != 8'hFF)
                stat_timeouts <= stat_timeouts + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_msx_ram_arbiter.sv
// Scoreboard bench for msx_ram_arbiter: stimulus pushes expected grants/acks, a negedge monitor pops and compares.
module tb_msx_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ld_req, cpu_req, cpu_rnw, dev_req, dev_rnw;
    logic [26:0] ld_addr, cpu_addr, dev_addr, mem_addr;
    logic [7:0]  ld_din, cpu_din, dev_din, cpu_dout, dev_dout, mem_din, mem_dout;
    logic        ld_ack, cpu_ack, cpu_wait_n, dev_ack;
    logic        mem_ce, mem_rnw, mem_done, timeout_err;
`ifdef RAM_ARB_STATS_EN
    logic [15:0] stat_ld, stat_cpu, stat_dev;
    logic [7:0]  stat_timeouts;
`endif

    always #5 clk = ~clk;

    msx_ram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
        .dev_req(dev_req), .dev_rnw(dev_rnw), .dev_addr(dev_addr), .dev_din(dev_din),
        .dev_dout(dev_dout), .dev_ack(dev_ack),
        .mem_ce(mem_ce), .mem_rnw(mem_rnw), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_done(mem_done), .timeout_err(timeout_err)
`ifdef RAM_ARB_STATS_EN
        , .stat_ld(stat_ld), .stat_cpu(stat_cpu), .stat_dev(stat_dev), .stat_timeouts(stat_timeouts)
`endif
    );

    typedef struct {logic rnw; logic [26:0] addr; logic [7:0] din;} grant_t;
    typedef struct {logic chk; logic [7:0] dat;} ack_t;

    grant_t exp_grant[$];
    ack_t   exp_cpu[$];
    ack_t   exp_dev[$];
    int     exp_ld_cnt = 0;
    int     n_vec = 0;
    int     n_miss = 0;

    // memory model knobs
    int       mem_delay = 1;
    logic     mem_stall = 1'b0;
    logic [7:0] rd_byte = 8'h00;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic bad(input string nm, input logic [63:0] act);
        n_vec++;
        n_miss++;
        $display("FAIL %s: observed %0h with nothing expected at %0t", nm, act, $time);
    endtask

    task automatic exp_g(input logic rnw, input logic [26:0] a, input logic [7:0] d);
        grant_t g;
        g.rnw = rnw; g.addr = a; g.din = d;
        exp_grant.push_back(g);
    endtask

    task automatic exp_a_cpu(input logic chk, input logic [7:0] d);
        ack_t a;
        a.chk = chk; a.dat = d;
        exp_cpu.push_back(a);
    endtask

    task automatic exp_a_dev(input logic chk, input logic [7:0] d);
        ack_t a;
        a.chk = chk; a.dat = d;
        exp_dev.push_back(a);
    endtask

    // Requester tasks: called at posedge+#1, return at posedge+#1 of the ack cycle with req dropped.
    task automatic ld_xact(input logic [26:0] a, input logic [7:0] d);
        int n;
        ld_addr = a; ld_din = d; ld_req = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ld_ack && n < 700);
        if (!ld_ack) bad("ld_ack_timeout", 0);
        ld_req = 1'b0;
    endtask

    task automatic cpu_xact(input logic rnw, input logic [26:0] a, input logic [7:0] d);
        int n;
        cpu_rnw = rnw; cpu_addr = a; cpu_din = d; cpu_req = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!cpu_ack && n < 700);
        if (!cpu_ack) bad("cpu_ack_timeout", 0);
        cpu_req = 1'b0;
    endtask

    task automatic dev_xact(input logic rnw, input logic [26:0] a, input logic [7:0] d);
        int n;
        dev_rnw = rnw; dev_addr = a; dev_din = d; dev_req = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!dev_ack && n < 700);
        if (!dev_ack) bad("dev_ack_timeout", 0);
        dev_req = 1'b0;
    endtask

    // Memory controller model: mem_done mem_delay cycles after the first mem_ce cycle.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_done = 1'b0;
        mem_dout = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (mem_done) begin
                mem_done = 1'b0;
                wcnt = 0;
            end else if (!mem_ce) begin
                wcnt = 0;
            end else if (!mem_stall) begin
                if (wcnt == mem_delay) begin
                    mem_done = 1'b1;
                    mem_dout = rd_byte;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic   prev_ce;
        grant_t g;
        ack_t   a;
        prev_ce = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_ce && !prev_ce) begin
                if (exp_grant.size() == 0) bad("unexpected_grant", {9'b0, mem_addr});
                else begin
                    g = exp_grant.pop_front();
                    check("grant_rnw_addr_din", {mem_rnw, mem_addr, mem_din}, {g.rnw, g.addr, g.din});
                end
            end
            prev_ce = mem_ce;
            if (ld_ack || cpu_ack || dev_ack)
                check("ack_onehot", 64'(ld_ack) + 64'(cpu_ack) + 64'(dev_ack), 1);
            if (ld_ack) begin
                if (exp_ld_cnt == 0) bad("unexpected_ld_ack", 1);
                else exp_ld_cnt--;
            end
            if (cpu_ack) begin
                if (exp_cpu.size() == 0) bad("unexpected_cpu_ack", {56'b0, cpu_dout});
                else begin
                    a = exp_cpu.pop_front();
                    if (a.chk) check("cpu_dout", cpu_dout, a.dat);
                end
            end
            if (dev_ack) begin
                if (exp_dev.size() == 0) bad("unexpected_dev_ack", {56'b0, dev_dout});
                else begin
                    a = exp_dev.pop_front();
                    if (a.chk) check("dev_dout", dev_dout, a.dat);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ce_cycles;
        reset_n = 1'b0;
        ld_req = 0; cpu_req = 0; dev_req = 0;
        cpu_rnw = 1; dev_rnw = 1;
        ld_addr = 0; cpu_addr = 0; dev_addr = 0;
        ld_din = 0; cpu_din = 0; dev_din = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_mem_ce", mem_ce, 0);
        check("rst_mem_rnw", mem_rnw, 1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_douts", {cpu_dout, dev_dout}, 0);
        check("rst_acks", {ld_ack, cpu_ack, dev_ack}, 0);
        check("rst_wait_n", cpu_wait_n, 1);
        check("rst_timeout_err", timeout_err, 0);

        // 1: single CPU read, cycle-exact
        @(posedge clk); #1;
        mem_delay = 1; rd_byte = 8'hA5;
        exp_g(1'b1, 27'h0004000, 8'h00);
        exp_a_cpu(1'b1, 8'hA5);
        cpu_rnw = 1; cpu_addr = 27'h0004000; cpu_din = 8'h00; cpu_req = 1;
        @(negedge clk);
        check("t1_wait_n_t0", cpu_wait_n, 0);
        check("t1_mem_ce_t0", mem_ce, 0);
        @(negedge clk);
        check("t1_mem_ce_t1", mem_ce, 1);
        check("t1_wait_n_t1", cpu_wait_n, 0);
        @(negedge clk);
        check("t1_mem_ce_t2", mem_ce, 1);
        check("t1_wait_n_t2", cpu_wait_n, 0);
        check("t1_ack_t2", cpu_ack, 0);
        @(negedge clk);
        check("t1_ack_t3", cpu_ack, 1);
        check("t1_wait_n_t3", cpu_wait_n, 1);
        check("t1_mem_ce_t3", mem_ce, 0);
        cpu_req = 0;

        // 2: all three requesters in the same cycle
        @(posedge clk); #1;
        rd_byte = 8'h3C;
        exp_g(1'b0, 27'h0000100, 8'h11);
        exp_g(1'b1, 27'h0002000, 8'h00);
        exp_g(1'b1, 27'h4000300, 8'h00);
        exp_ld_cnt = 1;
        exp_a_cpu(1'b1, 8'h3C);
        exp_a_dev(1'b1, 8'h3C);
        fork
            ld_xact(27'h0000100, 8'h11);
            cpu_xact(1'b1, 27'h0002000, 8'h00);
            dev_xact(1'b1, 27'h4000300, 8'h00);
        join

        // 3: CPU burst quota vs pending DEV
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) exp_g(1'b1, 27'h0001230, 8'h00);
        exp_g(1'b0, 27'h0400010, 8'hC3);
        for (int i = 0; i < 4; i++) exp_g(1'b1, 27'h0001230, 8'h00);
        exp_g(1'b0, 27'h0400010, 8'hC3);
        for (int i = 0; i < 8; i++) exp_a_cpu(1'b1, 8'h3C);
        exp_a_dev(1'b0, 8'h00);
        exp_a_dev(1'b0, 8'h00);
        fork
            begin
                int acks;
                acks = 0;
                cpu_rnw = 1; cpu_addr = 27'h0001230; cpu_din = 8'h00; cpu_req = 1;
                for (int c = 0; c < 200 && acks < 8; c++) begin
                    @(posedge clk); #1;
                    if (cpu_ack) acks++;
                end
                if (acks != 8) bad("t3_cpu_stream_timeout", 64'(acks));
                cpu_req = 0;
            end
            begin
                dev_xact(1'b0, 27'h0400010, 8'hC3);
                dev_xact(1'b0, 27'h0400010, 8'hC3);
            end
        join

        // mem_done on the last allowed WAIT_MEM cycle beats the timeout; top address
        @(posedge clk); #1;
        mem_delay = 255; rd_byte = 8'h5E;
        exp_g(1'b1, 27'h7FFFFFF, 8'h00);
        exp_a_cpu(1'b1, 8'h5E);
        cpu_xact(1'b1, 27'h7FFFFFF, 8'h00);
        check("edge_done_no_err", timeout_err, 0);

        // 4: stalled memory -> timeout
        @(posedge clk); #1;
        mem_delay = 1; mem_stall = 1;
        exp_g(1'b1, 27'h0002222, 8'h00);
        exp_a_cpu(1'b1, 8'hFF);
        cpu_rnw = 1; cpu_addr = 27'h0002222; cpu_din = 8'h00; cpu_req = 1;
        ce_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (mem_ce) ce_cycles++;
            if (cpu_ack) break;
        end
        check("t4_ack_seen", cpu_ack, 1);
        check("t4_mem_ce_cycles", 64'(ce_cycles), 256);
        check("t4_timeout_err", timeout_err, 1);
        cpu_req = 0;
        mem_stall = 0;
        @(posedge clk); #1;
        rd_byte = 8'h00;
        exp_g(1'b0, 27'h0003000, 8'h77);
        exp_a_dev(1'b0, 8'h00);
        dev_xact(1'b0, 27'h0003000, 8'h77);
        check("t4_err_sticky", timeout_err, 1);

        // 5: async reset in WAIT_MEM
        @(posedge clk); #1;
        mem_stall = 1;
        exp_g(1'b0, 27'h0005555, 8'h99);
        cpu_rnw = 0; cpu_addr = 27'h0005555; cpu_din = 8'h99; cpu_req = 1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t5_mem_ce_before", mem_ce, 1);
        reset_n = 1'b0;
        #1;
        check("t5_mem_ce_async", mem_ce, 0);
        check("t5_no_ack", cpu_ack, 0);
        check("t5_wait_n_in_reset", cpu_wait_n, 0);
        check("t5_err_cleared", timeout_err, 0);
        check("t5_rst_regs", {mem_rnw, mem_addr, cpu_dout}, {1'b1, 27'h0, 8'h00});
        cpu_req = 0;
        mem_stall = 0;
        #1;
        check("t5_wait_n_released", cpu_wait_n, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // fresh traffic after reset: 3 CPU + 2 DEV
        @(posedge clk); #1;
        rd_byte = 8'h42;
        exp_g(1'b1, 27'h0006000, 8'h00); exp_a_cpu(1'b1, 8'h42);
        cpu_xact(1'b1, 27'h0006000, 8'h00);
        exp_g(1'b0, 27'h0006001, 8'h24); exp_a_cpu(1'b0, 8'h00);
        cpu_xact(1'b0, 27'h0006001, 8'h24);
        exp_g(1'b1, 27'h0006002, 8'h00); exp_a_cpu(1'b1, 8'h42);
        cpu_xact(1'b1, 27'h0006002, 8'h00);
        exp_g(1'b0, 27'h0100000, 8'h55); exp_a_dev(1'b0, 8'h00);
        dev_xact(1'b0, 27'h0100000, 8'h55);
        exp_g(1'b1, 27'h0100001, 8'h00); exp_a_dev(1'b1, 8'h42);
        dev_xact(1'b1, 27'h0100001, 8'h00);
`ifdef RAM_ARB_STATS_EN
        @(negedge clk);
        check("stat_cpu", stat_cpu, 3);
        check("stat_dev", stat_dev, 2);
        check("stat_ld", stat_ld, 0);
        check("stat_timeouts", stat_timeouts, 0);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("grant_q_drained", 64'(exp_grant.size()), 0);
        check("cpu_q_drained", 64'(exp_cpu.size()), 0);
        check("dev_q_drained", 64'(exp_dev.size()), 0);
        check("ld_q_drained", 64'(exp_ld_cnt), 0);
        check("final_err_clear", timeout_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
